// File: rtl/onehot_stream_monitor.sv
// In-line checker for one-hot buses: registered zero/one/multi-hot classification,
// a saturating error count and a sticky alarm on a run of consecutive illegal words.
module onehot_stream_monitor #(
   parameter int DATA_WIDTH = 32,
   parameter int ALLOW_ZERO = 0,
   parameter int CNT_WIDTH  = 16,
   parameter int ALARM_LEN  = 4,
   parameter int IDX_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  din_valid,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  clear,
   output logic                  out_valid,
   output logic                  onehot,
   output logic                  zero,
   output logic                  multi,
   output logic [IDX_W-1:0]      index,
   output logic                  legal,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic                  alarm
);

   localparam int PC_W  = $clog2(DATA_WIDTH + 1);
   localparam int RUN_W = $clog2(ALARM_LEN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(ALARM_LEN);

   logic [PC_W-1:0]  pc;
   logic [IDX_W-1:0] idx_or;
   logic [IDX_W-1:0] idx_c;
   logic             zero_c, onehot_c, multi_c, legal_c;
   logic [RUN_W-1:0] run_cnt, run_inc;

   // OR-ing the positions of all set bits is the exact index only when one bit is set;
   // multi-hot words are masked to 0 below rather than priority-encoded.
   always_comb begin
      pc     = '0;
      idx_or = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         pc = pc + PC_W'(din[i]);
         if (din[i]) idx_or = idx_or | IDX_W'(i);
      end
   end

   always_comb begin
      zero_c   = (pc == '0);
      onehot_c = (pc == PC_W'(1));
      multi_c  = !zero_c && !onehot_c;
      idx_c    = onehot_c ? idx_or : '0;
      legal_c  = onehot_c | ((ALLOW_ZERO != 0) && zero_c);
      run_inc  = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         onehot    <= 1'b0;
         zero      <= 1'b0;
         multi     <= 1'b0;
         index     <= '0;
         legal     <= 1'b0;
         err_count <= '0;
         alarm     <= 1'b0;
         run_cnt   <= '0;
      end else begin
         out_valid <= din_valid;
         if (din_valid) begin
            onehot <= onehot_c;
            zero   <= zero_c;
            multi  <= multi_c;
            index  <= idx_c;
            legal  <= legal_c;
         end
         // clear wins over a simultaneous illegal sample, which is reported but not counted
         if (clear) begin
            err_count <= '0;
            run_cnt   <= '0;
            alarm     <= 1'b0;
         end else if (din_valid) begin
            if (!legal_c) begin
               if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
               run_cnt <= run_inc;
               if (run_inc == RUN_MAX) alarm <= 1'b1;
            end else begin
               run_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: doc/onehot_stream_monitor.md
Name: onehot_stream_monitor

Overview:
- Registered, streaming successor to the combinational one-hot detector.
- Classifies each valid input word as zero-hot, one-hot or multi-hot and reports the index of a one-hot bit.
- Keeps a saturating error count and raises a sticky alarm after a run of consecutive illegal words.
- Sits on one-hot select/grant buses as an in-line protocol checker.

Parameters:
- DATA_WIDTH, 32, width of the monitored word (>=2).
- ALLOW_ZERO, 0, 1 = an all-zero word is legal; 0 = exactly one bit must be set.
- CNT_WIDTH, 16, width of the saturating error counter.
- ALARM_LEN, 4, number of consecutive illegal valid words that sets the alarm (>=1).
- IDX_W, $clog2(DATA_WIDTH), width of the index output (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- din_valid  in  1  din is sampled this cycle.
- din  in  DATA_WIDTH  monitored word.
- clear  in  1  synchronous clear of err_count, the run counter and alarm.
- out_valid  out  1  result registers hold a new classification.
- onehot  out  1  last sampled word had exactly one bit set.
- zero  out  1  last sampled word was all zeros.
- multi  out  1  last sampled word had two or more bits set.
- index  out  IDX_W  bit position of the set bit when onehot=1, else 0.
- legal  out  1  onehot | (ALLOW_ZERO & zero).
- err_count  out  CNT_WIDTH  saturating count of illegal sampled words.
- alarm  out  1  sticky flag: ALARM_LEN consecutive illegal words were seen.

Behaviour:
- Reset, asynchronous: every output is 0 and the internal run counter is 0. This includes legal, even when ALLOW_ZERO=1.
- Latency: one cycle. A word sampled at edge N appears on all outputs after edge N, with out_valid=1 for exactly that cycle.
- Cycle with din_valid=0: out_valid goes 0 next cycle. onehot, zero, multi, index and legal hold their values. Counters are unchanged.
- Classification: popcount over DATA_WIDTH bits.
  - zero = (pc==0), onehot = (pc==1), multi = (pc>=2). Exactly one of the three is 1 after any sampled word.
- index:
  - Binary encoding of the single set bit when onehot.
  - Forced to 0 when zero or multi. No priority encoding of multi-hot words.
- Illegal word: a sampled word with legal=0.
- err_count:
  - +1 per illegal sampled word.
  - Saturates at 2^CNT_WIDTH-1; never wraps.
- Run counter: internal, saturating at ALARM_LEN.
  - +1 per illegal sampled word.
  - Reset to 0 by a legal sampled word.
  - Unaffected by cycles with din_valid=0.
- alarm:
  - Set in the same output cycle in which the run counter reaches ALARM_LEN.
  - Stays 1 until clear or reset. Later legal words do not drop it.
- clear, synchronous:
  - Next cycle err_count=0, run counter=0, alarm=0.
  - clear has priority over a simultaneous illegal sample: that sample is classified and reported normally (out_valid, flags, index) but is not counted.
  - clear does not affect the classification outputs.
- Reset asserted mid-stream: outputs drop to 0 immediately, without waiting for a clock edge. The first sample after reset release is classified normally.
- Fully synchronous datapath, no combinational path from inputs to outputs.

Test Plan:
- DATA_WIDTH=8, ALLOW_ZERO=0, ALARM_LEN=3, CNT_WIDTH=4. Apply din=8'h20 with din_valid=1 -> next cycle out_valid=1, onehot=1, index=5, legal=1, err_count=0.
- Same configuration. Apply 8'h00, then 8'h81, then 8'h03 on consecutive valid cycles -> zero=1, then multi=1 twice; legal=0 each time. err_count reads 1, 2, 3; alarm=1 in the third output cycle.
  - Then apply 8'h01 -> legal=1, alarm stays 1, err_count stays 3.
- Illegal, legal, illegal, illegal: 8'h03, 8'h04, 8'h0F, 8'hFF with ALARM_LEN=3 -> alarm remains 0 and err_count=3.
  - Then one idle cycle (din_valid=0) followed by 8'h11 -> alarm=1. Idle cycles do not break the run.
- Saturation: 20 multi-hot valid words with CNT_WIDTH=4 -> err_count reaches 15 and holds at 15.
  - Then assert clear together with din=8'h06 valid -> next cycle multi=1, out_valid=1, err_count=0, alarm=0.
- ALLOW_ZERO=1: apply 8'h00 -> zero=1, legal=1, err_count unchanged.
  - Assert reset asynchronously between clock edges -> all outputs read 0 before the next edge.
  - Release reset and apply 8'h80 -> index=7, onehot=1.
